// File: rtl/alu_result_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter with seven-segment drive for HEX0..HEX3.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits on HEX3..HEX1.
module alu_result_bcd_display #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned MAX_IN = (64'd1 << IN_W) - 64'd1;
    localparam bit              CFG_OK = pow10(DIGITS) > MAX_IN;
    localparam int              CW     = $clog2(IN_W + 1);
    localparam int              DW     = (DIGITS > 4) ? DIGITS : 4;

    generate
        if (!CFG_OK) begin : g_cfg_error
            $error("alu_result_bcd_display: DIGITS too small to hold 2^IN_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                state_q,   state_d;
    logic [IN_W-1:0]       shadow_q,  shadow_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]         count_q,   count_d;
    logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
    logic                  done_q,    done_d;
    logic [4*DIGITS-1:0]   adj;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        adj       = scratch_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d  = bin_in;
                    scratch_d = '0;
                    count_d   = CW'(IN_W);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Add-3 is nibble-local: a nibble >= 5 becomes at most 12, so no carry leaves it.
                for (int i = 0; i < DIGITS; i++) begin
                    if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
                end
                {scratch_d, shadow_d} = {adj, shadow_q} << 1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    // NOTE: every flop is reset, including the shadow/scratch datapath, so an aborted conversion leaves nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [4*DW-1:0]     bcd_pad;
    logic [DW-1:0][6:0]  seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic                lead;
`endif

    always_comb begin
        bcd_pad = (4*DW)'(bcd_q);
        seg     = '0;
`ifdef LEADING_ZERO_BLANK_EN
        // Walk from the top digit down; blank while only zeros have been seen, never the units digit.
        lead = 1'b1;
        for (int i = DW - 1; i >= 0; i--) begin
            if (bcd_pad[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead && (i != 0)) seg[i] = 7'b1111111;
            else                  seg[i] = seg7(bcd_pad[4*i +: 4]);
        end
`else
        for (int i = 0; i < DW; i++) seg[i] = seg7(bcd_pad[4*i +: 4]);
`endif
    end

    assign HEX0 = seg[0];
    assign HEX1 = seg[1];
    assign HEX2 = seg[2];
    assign HEX3 = seg[3];

endmodule

// File: tb/tb_alu_result_bcd_display.sv
// Self-checking bench for alu_result_bcd_display: directed and random conversions against a decimal-arithmetic model.
module tb_alu_result_bcd_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  bin_in = '0;
    logic        ready, busy, done;
    logic [15:0] bcd_out;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int checks = 0;
    int failures = 0;
    int exp_value = 0;

    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    always #5 clk = ~clk;

    alu_result_bcd_display #(.IN_W(10), .DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .HEX0    (hex0),
        .HEX1    (hex1),
        .HEX2    (hex2),
        .HEX3    (hex3)
    );

    function automatic logic [15:0] model_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] model_hex(input int v, input int idx);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < p) return 7'b1111111;
`endif
        return SEG[(v / p) % 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_display(input string tag, input int v);
        check({tag, "_hex0"}, hex0, model_hex(v, 0));
        check({tag, "_hex1"}, hex1, model_hex(v, 1));
        check({tag, "_hex2"}, hex2, model_hex(v, 2));
        check({tag, "_hex3"}, hex3, model_hex(v, 3));
    endtask

    // Called at a negedge with ready high; returns at the negedge where done is seen.
    task automatic convert(input int v);
        int n;
        logic prev_busy;
        start  = 1'b1;
        bin_in = 10'(v);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 10'($urandom);
        check("accept_ready", ready, 1'b0);
        check("accept_busy", busy, 1'b1);
        check("accept_done", done, 1'b0);
        check("hold_bcd", bcd_out, model_bcd(exp_value));
        n = 0;
        prev_busy = busy;
        while (!done && n < 40) begin
            prev_busy = busy;
            @(negedge clk);
            n++;
        end
        check("latency", n, 11);
        check("pre_done_busy", prev_busy, 1'b1);
        exp_value = v;
        check("bcd", bcd_out, model_bcd(v));
        check("done_ready", ready, 1'b1);
        check("done_busy", busy, 1'b0);
        check_display("conv", v);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd_out, 16'h0000);
        check_display("rst", 0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(1023);
        check("bcd_1023", bcd_out, 16'h1023);
        check("hex3_1023", hex3, 7'b1111001);
        check("hex2_1023", hex2, 7'b1000000);
        check("hex1_1023", hex1, 7'b0100100);
        check("hex0_1023", hex0, 7'b0110000);

        convert(0);
        check("bcd_0", bcd_out, 16'h0000);
        convert(599);
        check("bcd_599", bcd_out, 16'h0599);
        @(negedge clk);
        check("done_pulse_width", done, 1'b0);
        check("bcd_holds", bcd_out, 16'h0599);

        // Second start while busy must be ignored, not queued.
        start  = 1'b1;
        bin_in = 10'd42;
        @(negedge clk);
        start  = 1'b0;
        n = 0;
        repeat (2) begin @(negedge clk); n++; end
        start  = 1'b1;
        bin_in = 10'd900;
        @(negedge clk);
        n++;
        start  = 1'b0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        check("ign_latency", n, 11);
        check("ign_bcd", bcd_out, 16'h0042);
        exp_value = 42;
        @(negedge clk);
        check("ign_single_done", done, 1'b0);
        check("ign_no_queue", busy, 1'b0);
        check("ign_ready", ready, 1'b1);
        check("ign_bcd_hold", bcd_out, 16'h0042);

        convert(7);
        check("bcd_7", bcd_out, 16'h0007);
        check("hex0_7", hex0, 7'b1111000);

        for (int i = 0; i < 8; i++) convert(int'($urandom_range(0, 1023)));

        // Asynchronous reset in the middle of a conversion.
        start  = 1'b1;
        bin_in = 10'd777;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_bcd", bcd_out, 16'h0000);
        check_display("arst", 0);
        exp_value = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(509);
        check("bcd_509", bcd_out, 16'h0509);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
